// File: rtl/onehot_index_encoder_pipe_pkg.sv
// onehot_enc_pkg: mode encodings and width helper shared by the one-hot encoder files
package onehot_enc_pkg;
  localparam logic [1:0] MODE_STRICT  = 2'b00;
  localparam logic [1:0] MODE_PRIO_LO = 2'b01;
  localparam logic [1:0] MODE_PRIO_HI = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;
  typedef enum logic [1:0] {
    STRICT  = MODE_STRICT,
    PRIO_LO = MODE_PRIO_LO,
    PRIO_HI = MODE_PRIO_HI,
    RSVD    = MODE_RSVD
  } enc_mode_e;
  function automatic int idx_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/onehot_index_encoder_pipe_if.sv
// onehot_index_encoder_pipe_if: handshake, data, flag and telemetry bundle of the encoder
// master drives mode/in_valid/in_data/out_ready/err_clr; slave (the encoder) returns
// in_ready/out_valid/out_idx/out_zero/out_multi/err_cnt.
interface onehot_index_encoder_pipe_if
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  localparam int IDX_W = idx_w(WIDTH);
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_zero;
  logic             out_multi;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output mode, in_valid, in_data, out_ready, err_clr,
    input  in_ready, out_valid, out_idx, out_zero, out_multi, err_cnt
  );
  modport slave (
    input  mode, in_valid, in_data, out_ready, err_clr,
    output in_ready, out_valid, out_idx, out_zero, out_multi, err_cnt
  );
endinterface

// File: rtl/onehot_index_encoder_pipe_slice.sv
// onehot_enc_slice: combinational any/multi/lowest/highest set-bit finder for one slice
// data_i: slice bits; any_o: some bit set; multi_o: two or more set;
// low_idx_o/high_idx_o: lowest/highest set index, 0 when the slice is empty.
module onehot_enc_slice
  import onehot_enc_pkg::*;
#(
  parameter int SLICE_W = 32,
  localparam int SIW = idx_w(SLICE_W)
) (
  input  logic [SLICE_W-1:0] data_i,
  output logic               any_o,
  output logic               multi_o,
  output logic [SIW-1:0]     low_idx_o,
  output logic [SIW-1:0]     high_idx_o
);
  always_comb begin
    any_o      = |data_i;
    // clearing the lowest set bit leaves something only if two or more were set
    multi_o    = (data_i & (data_i - SLICE_W'(1))) != '0;
    low_idx_o  = '0;
    high_idx_o = '0;
    for (int i = SLICE_W - 1; i >= 0; i--) if (data_i[i]) low_idx_o = SIW'(i);
    for (int i = 0; i < SLICE_W; i++) if (data_i[i]) high_idx_o = SIW'(i);
  end
endmodule

// File: rtl/onehot_index_encoder_pipe.sv
// onehot_index_encoder_pipe: pipelined one-hot/multi-hot to binary index encoder
// clk, rst_n (sync, active-low); bus: slave side of onehot_index_encoder_pipe_if
// carrying the valid/ready input and output handshakes, flags and error counter.
module onehot_index_encoder_pipe
  import onehot_enc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  onehot_index_encoder_pipe_if.slave bus
);
  localparam int HW = WIDTH / 2;
  logic             src_valid, out_load, out_leave;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             zero_d, zero_q, multi_d, multi_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;
  assign out_leave = out_valid_q && bus.out_ready;
  assign out_load  = src_valid && (!out_valid_q || bus.out_ready);
  if (PIPE == 1) begin : g_p1
    logic             any, multi;
    logic [IDX_W-1:0] low, high;
    enc_mode_e        m;
    onehot_enc_slice #(.SLICE_W(WIDTH)) u_full (
      .data_i(bus.in_data), .any_o(any), .multi_o(multi), .low_idx_o(low), .high_idx_o(high)
    );
    assign m            = enc_mode_e'(bus.mode);
    assign src_valid    = bus.in_valid;
    assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
    assign zero_d       = !any;
    assign multi_d      = multi;
    // an empty slice reports index 0, so priority modes need no zero guard
    assign idx_d = m == PRIO_LO ? low : m == PRIO_HI ? high : multi ? '0 : low;
  end else if (PIPE == 2) begin : g_p2
    logic               any_lo, any_hi, mul_lo, mul_hi, s1_load, s1_valid_q;
    logic               any_lo_q, any_hi_q, mul_lo_q, mul_hi_q;
    logic [IDX_W-2:0]   lo_low, lo_high, hi_low, hi_high;
    logic [IDX_W-2:0]   lo_low_q, lo_high_q, hi_low_q, hi_high_q;
    enc_mode_e          mode_q;
    onehot_enc_slice #(.SLICE_W(HW)) u_lo (
      .data_i(bus.in_data[HW-1:0]), .any_o(any_lo), .multi_o(mul_lo),
      .low_idx_o(lo_low), .high_idx_o(lo_high)
    );
    onehot_enc_slice #(.SLICE_W(HW)) u_hi (
      .data_i(bus.in_data[WIDTH-1:HW]), .any_o(any_hi), .multi_o(mul_hi),
      .low_idx_o(hi_low), .high_idx_o(hi_high)
    );
    assign src_valid    = s1_valid_q;
    // stage 1 drains exactly when the output stage loads from it
    assign bus.in_ready = rst_n && (!s1_valid_q || out_load);
    assign s1_load      = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk)
      if (!rst_n) s1_valid_q <= 1'b0;
      else if (s1_load || out_load) s1_valid_q <= s1_load;
    always_ff @(posedge clk)
      if (s1_load) begin
        any_lo_q  <= any_lo;
        any_hi_q  <= any_hi;
        mul_lo_q  <= mul_lo;
        mul_hi_q  <= mul_hi;
        lo_low_q  <= lo_low;
        lo_high_q <= lo_high;
        hi_low_q  <= hi_low;
        hi_high_q <= hi_high;
        mode_q    <= enc_mode_e'(bus.mode);
      end
    assign zero_d  = !any_lo_q && !any_hi_q;
    assign multi_d = mul_lo_q || mul_hi_q || (any_lo_q && any_hi_q);
    assign idx_d = mode_q == PRIO_LO ? (any_lo_q ? {1'b0, lo_low_q} : any_hi_q ? {1'b1, hi_low_q} : '0)
                 : mode_q == PRIO_HI ? (any_hi_q ? {1'b1, hi_high_q} : {1'b0, lo_high_q})
                 : (multi_d || zero_d) ? '0
                 : any_hi_q ? {1'b1, hi_low_q} : {1'b0, lo_low_q};
  end else begin : g_bad_pipe
    $error("onehot_index_encoder_pipe: PIPE must be 1 or 2");
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      if (out_load || out_leave) out_valid_q <= out_load;
      if (out_load) begin
        idx_q   <= idx_d;
        zero_q  <= zero_d;
        multi_q <= multi_d;
      end
    end
  always_ff @(posedge clk)
    if (!rst_n || bus.err_clr) cnt_q <= '0;
    else if (out_leave && multi_q && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_multi = multi_q;
  assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_onehot_index_encoder_pipe.sv
// tb_onehot_index_encoder_pipe: randomized and directed checks of both pipeline depths against a popcount model
module tb_onehot_index_encoder_pipe;
  logic        clk, rst_n, sel, in_valid, out_ready, err_clr;
  logic [1:0]  mode;
  logic [63:0] in_data;
  int n_chk = 0, n_err = 0;
  onehot_index_encoder_pipe_if #(.WIDTH(64), .CNT_W(4))  ia ();
  onehot_index_encoder_pipe_if #(.WIDTH(64), .CNT_W(16)) ib ();
  onehot_index_encoder_pipe #(.WIDTH(64), .PIPE(2), .CNT_W(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  onehot_index_encoder_pipe #(.WIDTH(64), .PIPE(1), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  assign ia.mode = mode;
  assign ia.in_data = in_data;
  assign ia.in_valid = in_valid && !sel;
  assign ia.out_ready = out_ready && !sel;
  assign ia.err_clr = err_clr && !sel;
  assign ib.mode = mode;
  assign ib.in_data = in_data;
  assign ib.in_valid = in_valid && sel;
  assign ib.out_ready = out_ready && sel;
  assign ib.err_clr = err_clr && sel;
  wire        o_rdy  = sel ? ib.in_ready : ia.in_ready;
  wire        o_val  = sel ? ib.out_valid : ia.out_valid;
  wire [5:0]  o_idx  = sel ? ib.out_idx : ia.out_idx;
  wire        o_zero = sel ? ib.out_zero : ia.out_zero;
  wire        o_mul  = sel ? ib.out_multi : ia.out_multi;
  wire [15:0] o_cnt  = sel ? ib.err_cnt : {12'b0, ia.err_cnt};
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct { logic [5:0] idx; logic z; logic mu; int t; } exp_t;
  exp_t q[$];
  int cyc = 0;
  logic [15:0] exp_cnt = 0;
  bit was_rst = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask
  function automatic exp_t ref_enc(input logic [1:0] m, input logic [63:0] d, input int t);
    exp_t e;
    int cnt = 0, lo = -1, hi = -1;
    for (int i = 0; i < 64; i++) if (d[i]) begin
      cnt++;
      if (lo < 0) lo = i;
      hi = i;
    end
    e.z = cnt == 0;
    e.mu = cnt > 1;
    e.t = t;
    if (m == 2'b01) e.idx = lo < 0 ? 6'd0 : 6'(lo);
    else if (m == 2'b10) e.idx = hi < 0 ? 6'd0 : 6'(hi);
    else e.idx = cnt == 1 ? 6'(lo) : 6'd0;
    return e;
  endfunction
  function automatic logic [63:0] rnd_vec();
    case ($urandom_range(3))
      0: return 64'd0;
      1: return 64'd1 << $urandom_range(63);
      2: return (64'd1 << $urandom_range(63)) | (64'd1 << $urandom_range(63));
      default: return {$urandom, $urandom};
    endcase
  endfunction
  int mp;
  logic [15:0] mcm;
  logic ev;
  always @(negedge clk) begin
    mp = sel ? 1 : 2;
    mcm = sel ? 16'hffff : 16'h000f;
    cyc++;
    if (!rst_n) begin
      chk("in_ready_in_reset", o_rdy, 0);
      q.delete();
      exp_cnt = 0;
      was_rst = 1;
    end else begin
      if (was_rst) begin
        chk("rst_out_valid", o_val, 0);
        chk("rst_out_idx", o_idx, 0);
        chk("rst_out_zero", o_zero, 0);
        chk("rst_out_multi", o_mul, 0);
      end
      was_rst = 0;
      chk("err_cnt", o_cnt, exp_cnt);
      ev = 0;
      if (q.size() > 0) ev = (cyc - q[0].t) >= mp;
      chk("out_valid", o_val, ev);
      chk("in_ready", o_rdy, q.size() < mp || (o_val && out_ready));
      if (o_val && q.size() > 0) begin
        chk("out_idx", o_idx, q[0].idx);
        chk("out_zero", o_zero, q[0].z);
        chk("out_multi", o_mul, q[0].mu);
        if (out_ready) begin
          if (q[0].mu && exp_cnt != mcm) exp_cnt++;
          void'(q.pop_front());
        end
      end
      if (err_clr) exp_cnt = 0;
      if (in_valid && o_rdy) q.push_back(ref_enc(mode, in_data, cyc));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] m, input logic [63:0] d);
    int n = 0;
    mode = m;
    in_data = d;
    in_valid = 1;
    @(negedge clk);
    while (!o_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (q.size() > 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask
  initial begin
    #2_000_000;
    chk("watchdog_expired", 0, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    int bp[4] = '{3, 17, 33, 62};
    int p, k, n;
    bit took;
    rst_n = 0; sel = 0; mode = 0; in_valid = 0; in_data = 0; out_ready = 1; err_clr = 0;
    for (int u = 0; u < 2; u++) begin
      rst_n = 0;
      sel = u[0];
      p = u == 0 ? 2 : 1;
      repeat (3) tick();
      rst_n = 1;
      tick();
      send(2'b00, 64'd1 << 37);
      drain();
      chk("cnt_after_onehot", o_cnt, 0);
      send(2'b00, 64'h81);
      drain();
      chk("cnt_after_multi", o_cnt, 1);
      send(2'b01, 64'h8000_0000_0001_0100);
      send(2'b10, 64'h8000_0000_0001_0100);
      send(2'b10, 64'd1 << 40);
      drain();
      chk("cnt_after_prio", o_cnt, 3);
      for (int m = 0; m < 4; m++) send(2'(m), 64'd0);
      drain();
      chk("cnt_after_zero", o_cnt, 3);
      k = 0;
      mode = 2'b00;
      for (int c = 0; c < 14; c++) begin
        out_ready = c >= 5;
        in_valid = k < 4;
        in_data = 64'd1 << bp[k & 3];
        #1;
        took = in_valid && o_rdy;
        tick();
        if (took) k++;
        if (c == 4) begin
          chk("bp_accepts", k, p);
          chk("bp_hold_idx", o_idx, 3);
        end
      end
      in_valid = 0;
      chk("bp_all_sent", k, 4);
      drain();
      err_clr = 1;
      tick();
      err_clr = 0;
      for (int i = 0; i < 20; i++) send(2'b01, 64'h3 << (2 * i));
      drain();
      chk("cnt_saturate", o_cnt, u == 0 ? 15 : 20);
      out_ready = 0;
      send(2'b00, 64'h5);
      n = 0;
      while (!o_val && n < 20) begin
        tick();
        n++;
      end
      chk("clr_wait_valid", o_val, 1);
      out_ready = 1;
      err_clr = 1;
      tick();
      err_clr = 0;
      chk("clr_wins", o_cnt, 0);
      drain();
      for (int c = 0; c < 1500; c++) begin
        mode = 2'($urandom_range(3));
        in_valid = $urandom_range(3) != 0;
        in_data = rnd_vec();
        out_ready = $urandom_range(2) != 0;
        err_clr = $urandom_range(49) == 0;
        tick();
      end
      in_valid = 0;
      err_clr = 0;
      drain();
      out_ready = 0;
      mode = 2'b00;
      in_data = 64'h3;
      in_valid = 1;
      repeat (3) tick();
      in_valid = 0;
      rst_n = 0;
      tick();
      chk("midrst_out_valid", o_val, 0);
      chk("midrst_in_ready", o_rdy, 0);
      chk("midrst_err_cnt", o_cnt, 0);
      rst_n = 1;
      out_ready = 1;
      repeat (5) tick();
      chk("midrst_no_stale", o_val, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
